// File: rtl/reg_pipe_pkg.sv
// -----------------------------------------------------------------------------
// reg_pipe_pkg
//
// Purpose : Shared constants and helpers for the reg_pipe_syn_ah register
//           pipeline and its stage flop.
// Contents: DEFAULT_WIDTH  - default data width in bits
//           DEFAULT_DEPTH  - default number of pipeline stages
//           occ_width()    - bit width of an occupancy count able to hold 0..depth
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package reg_pipe_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned DEFAULT_DEPTH = 4;

   // Width of a counter holding 0..depth inclusive, i.e. clog2(depth+1).
   // A depth of 0 is not a legal pipeline, but a 1-bit result keeps any
   // port declared with this function well formed.
   function automatic int unsigned occ_width(input int unsigned depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage : reg_pipe_pkg

// File: rtl/d_ff_pet_syn_ah.sv
// -----------------------------------------------------------------------------
// d_ff_pet_syn_ah
//
// Purpose : One WIDTH-bit positive-edge-triggered register with synchronous
//           active-high reset, synchronous clear and enable. Used as a single
//           data or valid stage of reg_pipe_syn_ah.
//
// Priority: reset_ah_in > clr_in > en_in > hold.
//
// Ports   : clk          in   clock, all updates on the rising edge
//           reset_ah_in  in   synchronous reset, loads RESET_VAL
//           clr_in       in   synchronous clear (flush), loads RESET_VAL
//           en_in        in   load d_in when high, hold when low
//           d_in         in   WIDTH-bit next value
//           q_out        out  WIDTH-bit registered value
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module d_ff_pet_syn_ah
   import reg_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_ah_in,
   input  logic             clr_in,
   input  logic             en_in,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] q_out
);

   // NOTE: sequential state is assigned with <= so every flop in the chain
   // samples its neighbour's pre-edge value; with = the order of evaluation
   // would decide whether a word skips stages.
   always_ff @(posedge clk) begin
      if (reset_ah_in) begin
         q_out <= RESET_VAL;
      end else if (clr_in) begin
         q_out <= RESET_VAL;
      end else if (en_in) begin
         q_out <= d_in;
      end
   end

endmodule : d_ff_pet_syn_ah

// File: rtl/reg_pipe_syn_ah.sv
// -----------------------------------------------------------------------------
// reg_pipe_syn_ah
//
// Purpose : Parametrised register pipeline of DEPTH stages, each holding a
//           WIDTH-bit data word and a valid bit, with global stall (enable),
//           flush and a registered occupancy count. Generic delay/retiming
//           line between datapath blocks.
//
// Priority at every rising edge: reset_ah_in > flush_in > en_in > hold.
//   reset : data = RESET_VAL, valid = 0, occupancy = 0
//   flush : valid = 0, occupancy = 0; data = RESET_VAL when
//           CLEAR_DATA_ON_FLUSH = 1, otherwise data holds. The input word on
//           a flush edge is never captured.
//   advance (en_in = 1): stage 0 takes {valid_in, d_in}, every other stage
//           takes its predecessor; the last stage's word drops out.
//   stall (en_in = 0): everything holds.
//
// Latency : DEPTH-1 enabled edges after capture; all outputs are registered.
//
// Ports   : clk          in   clock
//           reset_ah_in  in   synchronous active-high reset
//           en_in        in   advance enable (0 = stall)
//           flush_in     in   synchronous flush of all valid bits
//           valid_in     in   qualifies d_in
//           d_in         in   WIDTH-bit data into stage 0
//           valid_out    out  valid bit of the last stage
//           q_out        out  data of the last stage
//           occ_out      out  number of stages whose valid bit is set
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module reg_pipe_syn_ah
   import reg_pipe_pkg::*;
#(
   parameter int unsigned      WIDTH               = DEFAULT_WIDTH,
   parameter int unsigned      DEPTH               = DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL           = '0,
   parameter bit               CLEAR_DATA_ON_FLUSH = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset_ah_in,
   input  logic                         en_in,
   input  logic                         flush_in,
   input  logic                         valid_in,
   input  logic [WIDTH-1:0]             d_in,
   output logic                         valid_out,
   output logic [WIDTH-1:0]             q_out,
   output logic [occ_width(DEPTH)-1:0]  occ_out
);

   localparam int unsigned OCC_W = occ_width(DEPTH);

   // Per-stage next values and registered values.
   logic [WIDTH-1:0] data_d  [DEPTH];
   logic [WIDTH-1:0] data_q  [DEPTH];
   logic             valid_d [DEPTH];
   logic             valid_q [DEPTH];

   // A flush must not let the data shift: when data is not cleared it holds,
   // so the data enable is suppressed on flush edges. The valid flops see the
   // flush through their own clear, which already outranks the enable.
   logic data_clr;
   logic data_en;

   assign data_clr = flush_in & CLEAR_DATA_ON_FLUSH;
   assign data_en  = en_in & ~flush_in;

   // NOTE: every data stage is reset, not just the valid bits, because
   // RESET_VAL is observable on q_out straight after reset.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign data_d[i]  = d_in;
         assign valid_d[i] = valid_in;
      end else begin : g_body
         assign data_d[i]  = data_q[i-1];
         assign valid_d[i] = valid_q[i-1];
      end

      d_ff_pet_syn_ah #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_data (
         .clk         (clk),
         .reset_ah_in (reset_ah_in),
         .clr_in      (data_clr),
         .en_in       (data_en),
         .d_in        (data_d[i]),
         .q_out       (data_q[i])
      );

      d_ff_pet_syn_ah #(
         .WIDTH     (1),
         .RESET_VAL (1'b0)
      ) u_valid (
         .clk         (clk),
         .reset_ah_in (reset_ah_in),
         .clr_in      (flush_in),
         .en_in       (en_in),
         .d_in        (valid_d[i]),
         .q_out       (valid_q[i])
      );
   end : g_stage

   // Occupancy: incremental update instead of a popcount tree. One word in
   // and one word out per advance, so the count moves by at most one and can
   // only reach DEPTH when the last stage is valid, which makes the
   // increment-and-drop cancel; the counter therefore never wraps.
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_next;

   // NOTE: occ_next gets its default first, so no path through this block
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      occ_next = occ_q;
      if (en_in) begin
         occ_next = occ_q + OCC_W'(valid_in) - OCC_W'(valid_q[DEPTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_ah_in) begin
         occ_q <= '0;
      end else if (flush_in) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_next;
      end
   end

   assign valid_out = valid_q[DEPTH-1];
   assign q_out     = data_q[DEPTH-1];
   assign occ_out   = occ_q;

endmodule : reg_pipe_syn_ah

// File: tb/tb_reg_pipe_syn_ah.sv
`timescale 1ns/1ps

module tb_reg_pipe_syn_ah;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 4;
   localparam logic [W-1:0] RV = 8'hA5;

   logic         clk = 1'b0;
   logic         reset_ah = 1'b1;
   logic         en = 1'b0;
   logic         flush = 1'b0;
   logic         vin = 1'b0;
   logic [W-1:0] din = '0;

   logic         v0, v1;
   logic [W-1:0] q0, q1;
   logic [2:0]   o0, o1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Instance 0 holds data on flush, instance 1 clears it; same stimulus.
   reg_pipe_syn_ah #(
      .WIDTH(W), .DEPTH(D), .RESET_VAL(RV), .CLEAR_DATA_ON_FLUSH(1'b0)
   ) dut0 (
      .clk(clk), .reset_ah_in(reset_ah), .en_in(en), .flush_in(flush),
      .valid_in(vin), .d_in(din), .valid_out(v0), .q_out(q0), .occ_out(o0)
   );

   reg_pipe_syn_ah #(
      .WIDTH(W), .DEPTH(D), .RESET_VAL(RV), .CLEAR_DATA_ON_FLUSH(1'b1)
   ) dut1 (
      .clk(clk), .reset_ah_in(reset_ah), .en_in(en), .flush_in(flush),
      .valid_in(vin), .d_in(din), .valid_out(v1), .q_out(q1), .occ_out(o1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each pipeline is a queue of words, front = newest. An advance pushes the
   // new word at the front and drops the oldest; the output is the oldest.
   typedef struct packed {
      logic         v;
      logic [W-1:0] d;
   } ent_t;

   ent_t m0[$];
   ent_t m1[$];
   bit   m_ok = 0;

   function automatic int count_valid(input ent_t q[$]);
      int n = 0;
      foreach (q[i]) if (q[i].v) n++;
      return n;
   endfunction

   always @(posedge clk) begin
      assert (!$isunknown({reset_ah, flush, en}))
         else $error("control input unknown at %0t", $time);
      if (reset_ah) begin
         m0 = {};
         m1 = {};
         for (int i = 0; i < D; i++) begin
            m0.push_back('{v: 1'b0, d: RV});
            m1.push_back('{v: 1'b0, d: RV});
         end
         m_ok = 1;
      end else if (m_ok && flush) begin
         foreach (m0[i]) m0[i].v = 1'b0;
         foreach (m1[i]) begin
            m1[i].v = 1'b0;
            m1[i].d = RV;
         end
      end else if (m_ok && en) begin
         m0.push_front('{v: vin, d: din});
         m1.push_front('{v: vin, d: din});
         void'(m0.pop_back());
         void'(m1.pop_back());
      end
   end

   // Compare process: every cycle once the model is defined.
   always @(negedge clk) begin
      if (m_ok) begin
         check("m0_valid", 32'(v0), 32'(m0[D-1].v));
         check("m0_q",     32'(q0), 32'(m0[D-1].d));
         check("m0_occ",   32'(o0), 32'(count_valid(m0)));
         check("m1_valid", 32'(v1), 32'(m1[D-1].v));
         check("m1_q",     32'(q1), 32'(m1[D-1].d));
         check("m1_occ",   32'(o1), 32'(count_valid(m1)));
      end
   end

   // ---------------- directed stimulus ----------------
   // Apply inputs, let one rising edge pass, return just after it.
   task automatic drive(input logic r, input logic f, input logic e,
                        input logic v, input logic [W-1:0] d);
      reset_ah = r;
      flush    = f;
      en       = e;
      vin      = v;
      din      = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       exp_v[8];
      logic [2:0] exp_o[8];
      logic [W-1:0] exp_q[8];

      // Reset for two cycles: reset state on both edges.
      for (int k = 0; k < 2; k++) begin
         drive(1, 0, 1, 1, 8'h33);
         check("rst_q",   32'(q0), 32'h0A5);
         check("rst_v",   32'(v0), 32'h0);
         check("rst_occ", 32'(o0), 32'h0);
      end

      // Streaming 1,2,3,...: first word out after edge 3, occupancy saturates at 4.
      for (int k = 0; k < 6; k++) begin
         drive(0, 0, 1, 1, W'(k + 1));
         check("str_occ", 32'(o0), (k < 3) ? 32'(k + 1) : 32'd4);
         check("str_v",   32'(v0), (k >= 3) ? 32'd1 : 32'd0);
         check("str_q",   32'(q0), (k >= 3) ? 32'(k - 2) : 32'h0A5);
      end

      // Stall: three words loaded, five stalled edges, then drain.
      drive(1, 0, 0, 0, 8'h00);
      drive(0, 0, 1, 1, 8'h11);
      drive(0, 0, 1, 1, 8'h12);
      drive(0, 0, 1, 1, 8'h13);
      check("ld_occ", 32'(o0), 32'd3);
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 1, (k % 2 == 0) ? 8'hFF : 8'h00);
         check("stl_q",   32'(q0), 32'h0A5);
         check("stl_v",   32'(v0), 32'd0);
         check("stl_occ", 32'(o0), 32'd3);
      end
      exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13;
      exp_o[0] = 3'd3;  exp_o[1] = 3'd2;  exp_o[2] = 3'd1;  exp_o[3] = 3'd0;
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 1, 0, 8'h00);
         check("drn_v",   32'(v0), (k < 3) ? 32'd1 : 32'd0);
         if (k < 3) check("drn_q", 32'(q0), 32'(exp_q[k]));
         check("drn_occ", 32'(o0), 32'(exp_o[k]));
      end

      // Bubbles: valid pattern 1,0,1,1 reappears four edges later.
      exp_v[0] = 0; exp_v[1] = 0; exp_v[2] = 0; exp_v[3] = 1;
      exp_v[4] = 0; exp_v[5] = 1; exp_v[6] = 1; exp_v[7] = 0;
      exp_o[0] = 3'd1; exp_o[1] = 3'd1; exp_o[2] = 3'd2; exp_o[3] = 3'd3;
      exp_o[4] = 3'd2; exp_o[5] = 3'd2; exp_o[6] = 3'd1; exp_o[7] = 3'd0;
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 1, (k == 0 || k == 2 || k == 3), (k < 4) ? W'(8'h21 + k) : 8'h00);
         check("bub_v",   32'(v0), 32'(exp_v[k]));
         check("bub_occ", 32'(o0), 32'(exp_o[k]));
         if (k == 3) check("bub_q3", 32'(q0), 32'h21);
         if (k == 6) check("bub_q6", 32'(q0), 32'h24);
      end

      // Flush with a valid input on the same edge.
      for (int k = 0; k < 4; k++) drive(0, 0, 1, 1, W'(8'h31 + k));
      check("pre_fl_occ", 32'(o0), 32'd4);
      check("pre_fl_q",   32'(q0), 32'h31);
      drive(0, 1, 1, 1, 8'h77);
      check("fl_v0",   32'(v0), 32'd0);
      check("fl_occ0", 32'(o0), 32'd0);
      check("fl_q0",   32'(q0), 32'h31);
      check("fl_v1",   32'(v1), 32'd0);
      check("fl_occ1", 32'(o1), 32'd0);
      check("fl_q1",   32'(q1), 32'h0A5);
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 1, 0, 8'h00);
         check("post_fl_v",   32'(v0 | v1), 32'd0);
         check("no77_q0",     32'(q0 == 8'h77), 32'd0);
         check("no77_q1",     32'(q1 == 8'h77), 32'd0);
      end

      // Reset outranks flush and enable.
      for (int k = 0; k < 4; k++) drive(0, 0, 1, 1, W'(8'h41 + k));
      check("pre_rst_q", 32'(q0), 32'h41);
      drive(1, 1, 1, 1, 8'h55);
      check("rfe_q0",   32'(q0), 32'h0A5);
      check("rfe_q1",   32'(q1), 32'h0A5);
      check("rfe_v",    32'(v0 | v1), 32'd0);
      check("rfe_occ0", 32'(o0), 32'd0);
      check("rfe_occ1", 32'(o1), 32'd0);

      drive(0, 0, 0, 0, 8'h00);
      drive(0, 0, 0, 0, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_reg_pipe_syn_ah
